// File: rtl/mont_exp_ctrl.sv
// mont_exp_ctrl: left-to-right square-and-multiply sequencer for an external
// Montgomery multiplier (product = A*B*R^-1 mod M, R = 2^BITS).
// Every exponent bit is processed. Each multiplier op is preceded by two idle
// GAP cycles with mm_go low, which lets the multiplier clear its done flag.
// Build option: define MONT_FINAL_CONVERT_EN to append one MM(acc, 1) op so the
// result leaves the Montgomery domain. Without it, result = X^E*R mod M.
module mont_exp_ctrl #(
   parameter int BITS = 64
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [BITS-1:0] x_bar,
   input  logic [BITS-1:0] one_bar,
   input  logic [BITS-1:0] e,
   input  logic [BITS-1:0] m,
   output logic            busy,
   output logic            done,
   output logic [BITS-1:0] result,
   output logic [BITS-1:0] mm_a,
   output logic [BITS-1:0] mm_b,
   output logic [BITS-1:0] mm_m,
   output logic            mm_go,
   input  logic            mm_done,
   input  logic [BITS-1:0] mm_s
);

   localparam int IW = (BITS > 1) ? $clog2(BITS) : 1;
   localparam logic [IW-1:0]   IDX_TOP = IW'(BITS - 1);
   localparam logic [IW-1:0]   IDX_ONE = IW'(1);
   localparam logic [BITS-1:0] MM_ONE  = {{(BITS-1){1'b0}}, 1'b1};

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      GAP    = 3'd1,
      SQ_RUN = 3'd2,
      MU_RUN = 3'd3,
      CV_RUN = 3'd4,
      FIN    = 3'd5
   } state_t;

   typedef enum logic [1:0] {
      OP_SQ = 2'd0,
      OP_MU = 2'd1,
      OP_CV = 2'd2
   } op_t;

   // Where the sequence goes once the last exponent bit is finished.
`ifdef MONT_FINAL_CONVERT_EN
   localparam state_t END_STATE = GAP;
`else
   localparam state_t END_STATE = FIN;
`endif

   // Registered state
   state_t          r_state;
   op_t             r_gap_op;
   logic            r_gap_cnt;
   logic [IW-1:0]   r_idx;
   logic [BITS-1:0] r_acc;
   logic [BITS-1:0] r_x;
   logic [BITS-1:0] r_e;
   logic [BITS-1:0] r_m;
   logic            r_busy;
   logic            r_done;
   logic            r_go;
   logic [BITS-1:0] r_a;
   logic [BITS-1:0] r_b;
   logic [BITS-1:0] r_result;

   // Next-state values
   state_t          w_state_nxt;
   op_t             w_gap_op_nxt;
   logic            w_gap_cnt_nxt;
   logic [IW-1:0]   w_idx_nxt;
   logic [BITS-1:0] w_acc_nxt;
   logic [BITS-1:0] w_a_nxt;
   logic [BITS-1:0] w_b_nxt;
   logic            w_latch;
   logic            w_run_nxt;

   assign busy   = r_busy;
   assign done   = r_done;
   assign result = r_result;
   assign mm_a   = r_a;
   assign mm_b   = r_b;
   assign mm_m   = r_m;
   assign mm_go  = r_go;

   assign w_run_nxt = (w_state_nxt == SQ_RUN) || (w_state_nxt == MU_RUN) ||
                      (w_state_nxt == CV_RUN);

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state decode plus accumulator/index/operand updates.
   always_comb begin
      w_state_nxt   = r_state;
      w_gap_op_nxt  = r_gap_op;
      w_gap_cnt_nxt = r_gap_cnt;
      w_idx_nxt     = r_idx;
      w_acc_nxt     = r_acc;
      w_a_nxt       = r_a;
      w_b_nxt       = r_b;
      w_latch       = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_state_nxt   = GAP;
               w_gap_op_nxt  = OP_SQ;
               w_gap_cnt_nxt = 1'b0;
               w_idx_nxt     = IDX_TOP;
               w_acc_nxt     = one_bar;
               w_latch       = 1'b1;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         GAP: begin
            if (r_gap_cnt) begin
               // Second idle cycle: present operands and launch the op.
               w_gap_cnt_nxt = 1'b0;
               w_a_nxt       = r_acc;
               case (r_gap_op)
                  OP_MU: begin
                     w_state_nxt = MU_RUN;
                     w_b_nxt     = r_x;
                  end
                  OP_CV: begin
                     w_state_nxt = CV_RUN;
                     w_b_nxt     = MM_ONE;
                  end
                  default: begin
                     w_state_nxt = SQ_RUN;
                     w_b_nxt     = r_acc;
                  end
               endcase
            end else begin
               w_gap_cnt_nxt = 1'b1;
            end
         end
         SQ_RUN: begin
            if (mm_done) begin
               w_acc_nxt     = mm_s;
               w_gap_cnt_nxt = 1'b0;
               if (r_e[r_idx]) begin
                  w_state_nxt  = GAP;
                  w_gap_op_nxt = OP_MU;
               end else if (r_idx == '0) begin
                  w_state_nxt  = END_STATE;
                  w_gap_op_nxt = OP_CV;
               end else begin
                  w_state_nxt  = GAP;
                  w_gap_op_nxt = OP_SQ;
                  w_idx_nxt    = r_idx - IDX_ONE;
               end
            end else begin
               w_state_nxt = SQ_RUN;
            end
         end
         MU_RUN: begin
            if (mm_done) begin
               w_acc_nxt     = mm_s;
               w_gap_cnt_nxt = 1'b0;
               if (r_idx == '0) begin
                  w_state_nxt  = END_STATE;
                  w_gap_op_nxt = OP_CV;
               end else begin
                  w_state_nxt  = GAP;
                  w_gap_op_nxt = OP_SQ;
                  w_idx_nxt    = r_idx - IDX_ONE;
               end
            end else begin
               w_state_nxt = MU_RUN;
            end
         end
         CV_RUN: begin
            if (mm_done) begin
               w_acc_nxt   = mm_s;
               w_state_nxt = FIN;
            end else begin
               w_state_nxt = CV_RUN;
            end
         end
         FIN: begin
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // Datapath registers: latched operands, accumulator, bit index, gap tracking.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_gap_op  <= OP_SQ;
         r_gap_cnt <= 1'b0;
         r_idx     <= IDX_TOP;
         r_acc     <= '0;
         r_x       <= '0;
         r_e       <= '0;
         r_m       <= '0;
         r_a       <= '0;
         r_b       <= '0;
      end else begin
         r_gap_op  <= w_gap_op_nxt;
         r_gap_cnt <= w_gap_cnt_nxt;
         r_idx     <= w_idx_nxt;
         r_acc     <= w_acc_nxt;
         r_a       <= w_a_nxt;
         r_b       <= w_b_nxt;
         if (w_latch) begin
            r_x <= x_bar;
            r_e <= e;
            r_m <= m;
         end
      end
   end

   // Registered status outputs derived from the upcoming state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_go     <= 1'b0;
         r_result <= '0;
      end else begin
         r_busy <= (w_state_nxt != IDLE);
         r_done <= (w_state_nxt == FIN);
         r_go   <= w_run_nxt;
         if (w_state_nxt == FIN) begin
            r_result <= w_acc_nxt;
         end
      end
   end

endmodule

// File: tb/tb_mont_exp_ctrl.sv
// Directed bench for mont_exp_ctrl (BITS=64) paired with a behavioural
// Montgomery multiplier of random 1..4 cycle latency. Expected results are
// hand-computed for m=13 (R mod 13 = 3) in both build configurations.
module tb_mont_exp_ctrl;

   logic        clk;
   logic        rst;
   logic        start;
   logic [63:0] x_bar;
   logic [63:0] one_bar;
   logic [63:0] e;
   logic [63:0] m;
   logic        busy;
   logic        done;
   logic [63:0] result;
   logic [63:0] mm_a;
   logic [63:0] mm_b;
   logic [63:0] mm_m;
   logic        mm_go;
   logic        mm_done;
   logic [63:0] mm_s;

`ifdef MONT_FINAL_CONVERT_EN
   localparam int          NCV     = 1;
   localparam logic [63:0] EXP_2_5 = 64'd6;
   localparam logic [63:0] EXP_7_0 = 64'd1;
   localparam logic [63:0] EXP_7_1 = 64'd7;
   localparam logic [63:0] EXP_7_F = 64'd5;
   localparam logic [63:0] EXP_3_4 = 64'd3;
`else
   localparam int          NCV     = 0;
   localparam logic [63:0] EXP_2_5 = 64'd5;
   localparam logic [63:0] EXP_7_0 = 64'd3;
   localparam logic [63:0] EXP_7_1 = 64'd8;
   localparam logic [63:0] EXP_7_F = 64'd2;
   localparam logic [63:0] EXP_3_4 = 64'd9;
`endif

   int total = 0;
   int bad   = 0;

   // monitor state
   int          n_rise = 0, n_sq = 0, n_mu = 0, n_cv = 0;
   int          ops_bad = 0, gap_bad = 0, done_cnt = 0, low_cnt = 0;
   int          mon_i = 63, mon_kind = 3;
   logic        mon_prev_go = 1'b0;
   logic [63:0] cap_a = '0, cap_b = '0;
   logic [63:0] run_xb = '0, run_e = '0, run_m = '0;

   // multiplier model state
   int   lat = 0;
   logic armed = 1'b0;

   logic [63:0] res;
   bit          ok;

   mont_exp_ctrl #(.BITS(64)) dut (
      .clk(clk), .rst(rst), .start(start),
      .x_bar(x_bar), .one_bar(one_bar), .e(e), .m(m),
      .busy(busy), .done(done), .result(result),
      .mm_a(mm_a), .mm_b(mm_b), .mm_m(mm_m), .mm_go(mm_go),
      .mm_done(mm_done), .mm_s(mm_s)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [63:0] mont(input logic [63:0] a, input logic [63:0] b,
                                        input logic [63:0] mm);
      logic [65:0] t;
      t = '0;
      for (int i = 0; i < 64; i++) begin
         if (a[i]) t = t + {2'b00, b};
         if (t[0]) t = t + {2'b00, mm};
         t = t >> 1;
      end
      if (t >= {2'b00, mm}) t = t - {2'b00, mm};
      return t[63:0];
   endfunction

   // Behavioural multiplier: done follows go after a random latency, clears when go drops.
   always @(posedge clk) begin
      if (!mm_go) begin
         mm_done <= 1'b0;
         armed   <= 1'b0;
      end else if (!mm_done) begin
         if (!armed) begin
            armed <= 1'b1;
            lat   <= int'($urandom_range(0, 3));
         end else if (lat == 0) begin
            mm_done <= 1'b1;
            mm_s    <= mont(mm_a, mm_b, mm_m);
         end else begin
            lat <= lat - 1;
         end
      end
   end

   // Op-sequence, operand-stability, gap-length and done-pulse monitor.
   always @(negedge clk) begin
      if (mm_go && !mon_prev_go) begin
         n_rise++;
         if (low_cnt != 2) gap_bad++;
         low_cnt = 0;
         cap_a = mm_a;
         cap_b = mm_b;
         if (mm_m !== run_m) ops_bad++;
         case (mon_kind)
            0: begin
               n_sq++;
               if (mm_a !== mm_b) ops_bad++;
               if (run_e[mon_i]) mon_kind = 1;
               else if (mon_i == 0) mon_kind = (NCV == 1) ? 2 : 3;
               else mon_i--;
            end
            1: begin
               n_mu++;
               if (mm_b !== run_xb) ops_bad++;
               if (mon_i == 0) mon_kind = (NCV == 1) ? 2 : 3;
               else begin
                  mon_i--;
                  mon_kind = 0;
               end
            end
            2: begin
               n_cv++;
               if (mm_b !== 64'd1) ops_bad++;
               mon_kind = 3;
            end
            default: ops_bad++;
         endcase
      end else if (mm_go) begin
         if (mm_a !== cap_a || mm_b !== cap_b) ops_bad++;
      end else if (busy) begin
         low_cnt++;
      end else begin
         low_cnt = 0;
      end
      if (done) done_cnt++;
      mon_prev_go = mm_go;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic start_op(input logic [63:0] xb, input logic [63:0] ob,
                           input logic [63:0] ee, input logic [63:0] mm);
      @(posedge clk); #1;
      x_bar = xb; one_bar = ob; e = ee; m = mm; start = 1'b1;
      run_xb = xb; run_e = ee; run_m = mm;
      n_rise = 0; n_sq = 0; n_mu = 0; n_cv = 0;
      ops_bad = 0; gap_bad = 0; done_cnt = 0;
      mon_i = 63; mon_kind = 0;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(output logic [63:0] r, output bit got);
      got = 1'b0;
      r   = '0;
      for (int c = 0; c < 3000; c++) begin
         if (done === 1'b1) begin
            got = 1'b1;
            r   = result;
            break;
         end
         @(posedge clk); #1;
      end
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0;
      x_bar = '0; one_bar = '0; e = '0; m = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy",   64'(busy),   64'd0);
      chk("rst_done",   64'(done),   64'd0);
      chk("rst_mm_go",  64'(mm_go),  64'd0);
      chk("rst_result", result,      64'd0);
      chk("rst_mm_a",   mm_a,        64'd0);
      chk("rst_mm_m",   mm_m,        64'd0);
      rst = 1'b0;

      // X=2, e=5, m=13
      start_op(64'd6, 64'd3, 64'd5, 64'd13);
      chk("t1_busy_after_accept", 64'(busy), 64'd1);
      wait_done(res, ok);
      chk("t1_done_seen", 64'(ok), 64'd1);
      chk("t1_result",    res, EXP_2_5);
      chk("t1_done_cnt",  64'(done_cnt), 64'd1);
      chk("t1_rises",     64'(n_rise), 64'(66 + NCV));
      chk("t1_squares",   64'(n_sq), 64'd64);
      chk("t1_mults",     64'(n_mu), 64'd2);
      chk("t1_converts",  64'(n_cv), 64'(NCV));
      chk("t1_ops_bad",   64'(ops_bad), 64'd0);
      chk("t1_gap_bad",   64'(gap_bad), 64'd0);
      chk("t1_idle_busy", 64'(busy), 64'd0);
      chk("t1_result_held", result, EXP_2_5);

      // X=7, e=0 / e=1 / e=all-ones
      start_op(64'd8, 64'd3, 64'd0, 64'd13);
      wait_done(res, ok);
      chk("e0_result",  res, EXP_7_0);
      chk("e0_rises",   64'(n_rise), 64'(64 + NCV));
      chk("e0_ops_bad", 64'(ops_bad), 64'd0);

      start_op(64'd8, 64'd3, 64'd1, 64'd13);
      wait_done(res, ok);
      chk("e1_result",  res, EXP_7_1);
      chk("e1_rises",   64'(n_rise), 64'(65 + NCV));

      start_op(64'd8, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd13);
      wait_done(res, ok);
      chk("eF_result",  res, EXP_7_F);
      chk("eF_rises",   64'(n_rise), 64'(128 + NCV));
      chk("eF_ops_bad", 64'(ops_bad), 64'd0);
      chk("eF_gap_bad", 64'(gap_bad), 64'd0);

      // reset during the 10th square, then a fresh run X=3, e=4
      start_op(64'd6, 64'd3, 64'd5, 64'd13);
      for (int c = 0; c < 2000; c++) begin
         if (n_rise == 10) break;
         @(posedge clk); #1;
      end
      chk("rs_reached_sq10", 64'(n_rise), 64'd10);
      chk("rs_go_before",    64'(mm_go), 64'd1);
      rst = 1'b1;
      #1;
      chk("rs_go_low",   64'(mm_go), 64'd0);
      chk("rs_busy_low", 64'(busy), 64'd0);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("rs_no_done", 64'(done_cnt), 64'd0);
      chk("rs_result",  result, 64'd0);
      start_op(64'd9, 64'd3, 64'd4, 64'd13);
      wait_done(res, ok);
      chk("rs_restart_result", res, EXP_3_4);
      chk("rs_restart_rises",  64'(n_rise), 64'(65 + NCV));

      // start pulse and operand changes mid-run are ignored
      start_op(64'd6, 64'd3, 64'd5, 64'd13);
      repeat (40) @(posedge clk);
      #1;
      start = 1'b1; x_bar = 64'd8; one_bar = 64'd0; e = 64'hFFFF_FFFF_FFFF_FFFF; m = 64'd11;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(res, ok);
      chk("mid_result",   res, EXP_2_5);
      chk("mid_done_cnt", 64'(done_cnt), 64'd1);
      chk("mid_rises",    64'(n_rise), 64'(66 + NCV));
      chk("mid_ops_bad",  64'(ops_bad), 64'd0);
      chk("mid_gap_bad",  64'(gap_bad), 64'd0);

      // start on the IDLE cycle right after FIN is accepted
      start_op(64'd9, 64'd3, 64'd4, 64'd13);
      for (int c = 0; c < 3000; c++) begin
         if (done === 1'b1) break;
         @(posedge clk); #1;
      end
      chk("b2b_first_done", 64'(done), 64'd1);
      @(posedge clk); #1;
      x_bar = 64'd8; e = 64'd1; start = 1'b1;
      run_xb = 64'd8; run_e = 64'd1;
      n_rise = 0; n_sq = 0; n_mu = 0; n_cv = 0; ops_bad = 0; gap_bad = 0;
      mon_i = 63; mon_kind = 0;
      @(posedge clk); #1;
      start = 1'b0;
      chk("b2b_accepted", 64'(busy), 64'd1);
      wait_done(res, ok);
      chk("b2b_result", res, EXP_7_1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mont_exp_ctrl.md
MONT_EXP_CTRL -- requirements
Module: mont_exp_ctrl

Interface
REQ-001 SHALL have parameter BITS, default 64, operand/modulus width (matches multiplier width).
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request one exponentiation; sampled in IDLE only.
REQ-005 SHALL have ports x_bar  input  BITS  base in Montgomery form (X*R mod M, R=2^BITS); one_bar  input  BITS  R mod M.
REQ-006 SHALL have ports e  input  BITS  exponent; m  input  BITS  modulus, odd, m < 2^(BITS-1).
REQ-007 SHALL have ports busy  output  1  operation in progress; done  output  1  one-cycle completion pulse; result  output  BITS  final value.
REQ-008 SHALL have ports mm_a, mm_b, mm_m  output  BITS  multiplier operands; mm_go  output  1  multiplier go.
REQ-009 SHALL have ports mm_done  input  1  multiplier done; mm_s  input  BITS  multiplier product A*B*R^-1 mod M.

Function
REQ-010 SHALL latch x_bar, one_bar, e, m on the cycle start=1 in IDLE; later input changes SHALL NOT affect the operation.
REQ-011 SHALL compute left-to-right square-and-multiply: acc=one_bar; for i=BITS-1 down to 0: acc=MM(acc,acc); if e[i] then acc=MM(acc,x_bar).
REQ-012 SHALL process all BITS exponent bits (no leading-zero skip): exactly BITS squares plus popcount(e) multiplies, plus the REQ-027 conversion.
REQ-013 SHALL use states IDLE, GAP, SQ_RUN, MU_RUN, CV_RUN, FIN; GAP records which op follows.
REQ-014 SHALL precede every multiplier op, including the first, with exactly 2 GAP cycles holding mm_go=0; this clears the multiplier's done.
REQ-015 SHALL hold mm_go=1 and mm_a/mm_b/mm_m stable throughout *_RUN until mm_done=1 is sampled.
REQ-016 SHALL capture mm_s into acc on the edge where mm_done=1 in *_RUN, deassert mm_go that same edge, and enter GAP or FIN.
REQ-017 SHALL drive SQ_RUN with mm_a=mm_b=acc, MU_RUN with mm_a=acc, mm_b=x_bar, and mm_m=latched m in all ops.
REQ-018 SHALL transition: SQ_RUN done -> GAP(MU) if e[i]=1, else GAP(SQ) with i-1; MU_RUN done -> GAP(SQ) with i-1; last bit (i=0) -> GAP(CV), or FIN if conversion is disabled.
REQ-019 SHALL use a bit index counter of width clog2(BITS) that counts down from BITS-1 and does not wrap below 0.
REQ-020 SHALL spend exactly one cycle in FIN: result<=acc, done=1, then return to IDLE.
REQ-021 SHALL hold busy=1 from the edge after start is accepted through FIN inclusive; busy=0 in IDLE.
REQ-022 SHALL ignore start while busy=1; start=1 in the IDLE cycle that follows FIN SHALL be accepted.
REQ-023 SHALL ignore mm_done in GAP and IDLE.
REQ-024 SHALL hold result until the next FIN.

Reset
REQ-025 SHALL, on rst=1 at any time, asynchronously force IDLE, busy=0, done=0, mm_go=0, result=0, acc=0, index=BITS-1, mm_a=mm_b=mm_m=0.
REQ-026 SHALL, on rst mid-operation, abandon the operation with no done pulse; the first start after reset release SHALL run a complete new operation.

Configuration
REQ-027 SHALL, with macro MONT_FINAL_CONVERT_EN defined, add one op CV_RUN (mm_a=acc, mm_b=1) after the last bit so that result=X^E mod M in normal domain.
REQ-028 SHALL, without MONT_FINAL_CONVERT_EN, omit CV_RUN and return result=acc in Montgomery form (X^E*R mod M).

Verification (BITS=64, MONT_FINAL_CONVERT_EN defined unless noted, bench pairs block with behavioural Montgomery multiplier of variable latency)
REQ-029 SHALL cover: m=13, X=2, e=5 -> single done pulse, result=6, exactly 64 squares + 2 multiplies + 1 convert observed on mm_go rises.
REQ-030 SHALL cover: m=13, X=7, e=0 -> result=1; e=1 -> result=7; e=2^64-1 -> result equals model 7^(2^64-1) mod 13.
REQ-031 SHALL cover: MONT_FINAL_CONVERT_EN undefined, m=13, X=2, e=5 -> result=(32*2^64) mod 13.
REQ-032 SHALL cover: assert rst during 10th square -> mm_go, busy low immediately, no done; restart with X=3, e=4, m=13 -> result=3.
REQ-033 SHALL cover: start pulsed while busy and change x_bar/e mid-run -> ignored, result matches original operands; mm_go low exactly 2 cycles between every pair of ops.
